// File: rtl/addsub_result_stage.sv
// addsub_result_stage: registers add/sub results with {V,N,Z,C} flags into a
// small valid/ready FIFO and keeps saturating op counters plus a sticky overflow.
`default_nettype none

module addsub_result_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_cout,
  input  logic             in_ctrl,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] add_cnt,
  output logic [CNT_W-1:0] sub_cnt,
  output logic             ovf_sticky,
  input  logic             cnt_clr
);

  localparam int ENT_W = WIDTH + 4;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] add_cnt_q, add_cnt_d;
  logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             ovf_q, ovf_d;

  logic             flag_v, flag_n, flag_z, flag_c;
  logic             push, pop;
  logic [CNT_W-1:0] add_base, sub_base;
  logic [ENT_W-1:0] head;

  // b's sign is taken before inversion, so subtract overflow needs differing operand signs.
  assign flag_n = in_s[WIDTH-1];
  assign flag_z = (in_s == '0);
  assign flag_c = in_ctrl ? ~in_cout : in_cout;
  assign flag_v = (in_ctrl ? (in_a_msb != in_b_msb) : (in_a_msb == in_b_msb))
                  & (flag_n != in_a_msb);

  assign in_ready  = (occ_q != FULL_OCC);
  assign out_valid = (occ_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head      = mem_q[rd_ptr_q];
  assign out_s     = out_valid ? head[WIDTH-1:0] : '0;
  assign out_flags = out_valid ? head[ENT_W-1:WIDTH] : 4'b0000;

  assign add_cnt    = add_cnt_q;
  assign sub_cnt    = sub_cnt_q;
  assign ovf_sticky = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Clear takes effect first so an op accepted alongside it still counts.
  always_comb begin
    add_base  = cnt_clr ? '0 : add_cnt_q;
    sub_base  = cnt_clr ? '0 : sub_cnt_q;
    add_cnt_d = add_base;
    sub_cnt_d = sub_base;
    ovf_d     = (cnt_clr ? 1'b0 : ovf_q) | (push & flag_v);
    if (push && !in_ctrl && add_base != CNT_MAX) add_cnt_d = add_base + CNT_W'(1);
    if (push &&  in_ctrl && sub_base != CNT_MAX) sub_cnt_d = sub_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      add_cnt_q <= '0;
      sub_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= {flag_v, flag_n, flag_z, flag_c, in_s};
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      add_cnt_q <= add_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_addsub_result_stage.sv
// tb_addsub_result_stage: directed vectors with hand-computed expectations.
`default_nettype none

module tb_addsub_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [3:0] in_s;
  logic       in_cout, in_ctrl, in_a_msb, in_b_msb;
  logic       out_valid, out_ready;
  logic [3:0] out_s, out_flags;
  logic [7:0] add_cnt, sub_cnt;
  logic       ovf_sticky, cnt_clr;

  int n_vec  = 0;
  int n_miss = 0;

  addsub_result_stage #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s), .in_cout(in_cout),
    .in_ctrl(in_ctrl), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_flags(out_flags),
    .add_cnt(add_cnt), .sub_cnt(sub_cnt), .ovf_sticky(ovf_sticky), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic co,
                       input logic ctl, input logic am, input logic bm);
    in_valid = v; in_s = s; in_cout = co; in_ctrl = ctl; in_a_msb = am; in_b_msb = bm;
  endtask

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_s", out_s, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_add_cnt", add_cnt, 0);
    check("rst_sub_cnt", sub_cnt, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Add 7+1 overflows into negative.
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_s", out_s, 4'b1000);
    check("t1_flags", out_flags, 4'b1100);
    check("t1_ovf", ovf_sticky, 1);
    check("t1_add_cnt", add_cnt, 1);
    out_ready = 1'b1;
    step();
    check("t1_drained", out_valid, 0);

    // Sub 5-5 then 3-5; second push coincides with first pop.
    drive(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("t2a_valid", out_valid, 1);
    check("t2a_flags", out_flags, 4'b0010);
    check("t2a_sub_cnt", sub_cnt, 1);
    drive(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2b_s", out_s, 4'b1110);
    check("t2b_flags", out_flags, 4'b0101);
    check("t2b_sub_cnt", sub_cnt, 2);
    step();
    check("t2_drained", out_valid, 0);

    // Fill with out_ready low; third input stalls until a slot frees.
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("t3_ready_after1", in_ready, 1);
    drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("t3_ready_after2", in_ready, 0);
    drive(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("t3_held_ready", in_ready, 0);
    check("t3_head_a", out_s, 4'h1);
    out_ready = 1'b1;
    step();
    check("t3_head_b", out_s, 4'h2);
    check("t3_ready_freed", in_ready, 1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_head_c", out_s, 4'h3);
    check("t3_flags_c", out_flags, 4'b0001);
    step();
    check("t3_drained", out_valid, 0);
    check("t3_add_cnt", add_cnt, 4);

    // One entry held, then simultaneous push and pop.
    out_ready = 1'b0;
    drive(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    out_ready = 1'b1;
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_valid", out_valid, 1);
    check("t4_head_new", out_s, 4'h5);
    check("t4_ready", in_ready, 1);
    step();
    check("t4_single", out_valid, 0);

    // Clear, then saturate the add counter.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("t5_clr_add", add_cnt, 0);
    check("t5_clr_ovf", ovf_sticky, 0);
    drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) step();
    check("t5_sat", add_cnt, 255);
    step();
    check("t5_sat_held", add_cnt, 255);
    cnt_clr = 1'b1;
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    cnt_clr = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_clr_op_add", add_cnt, 0);
    check("t5_clr_op_sub", sub_cnt, 1);
    check("t5_clr_op_ovf", ovf_sticky, 1);
    step();
    step();

    // Asynchronous reset with a full FIFO.
    out_ready = 1'b0;
    drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("t6_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_s", out_s, 0);
    check("t6_add_cnt", add_cnt, 0);
    check("t6_sub_cnt", sub_cnt, 0);
    check("t6_ovf", ovf_sticky, 0);
    check("t6_ready", in_ready, 1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_resume_s", out_s, 4'h7);
    check("t6_resume_cnt", add_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
